// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 receive path.
// Holds the default panel geometry, the colour-channel index map used to
// pack the six serial data lines into one vector, and the receiver FSM
// state encoding.
package hub75_pkg;

  localparam int DEFAULT_PANEL_WIDTH = 32;
  localparam int DEFAULT_ADDR_W      = 4;

  localparam int NUM_CH = 6;
  localparam int CH_R0  = 0;
  localparam int CH_G0  = 1;
  localparam int CH_B0  = 2;
  localparam int CH_R1  = 3;
  localparam int CH_G1  = 4;
  localparam int CH_B1  = 5;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/hub75_sync_edge.sv
// Two-flop synchroniser with registered edge pulses.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   din   asynchronous input bits
//   level synchronised level, aligned with the edge pulses
//   rise  one-cycle pulse per synchronised rising edge
//   fall  one-cycle pulse per synchronised falling edge
module hub75_sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Edge pulses are registered so every downstream consumer sees them in
  // the same cycle as the delayed level, keeping data and strobes aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign level = prev_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/hub75_receiver.sv
// HUB75 bus receiver: deserialises each panel row and emits one record per
// LATCH over a valid/ready handshake.
// Ports:
//   CLK_I, RST_I                  system clock, synchronous active-high reset
//   HUB_R0..HUB_B1                serial colour data (asynchronous)
//   HUB_ADDR, HUB_CLK, HUB_LATCH, HUB_OE   panel control (asynchronous)
//   ROW_VALID / ROW_READY         record handshake
//   ROW_ADDR, ROW_RED0..ROW_BLU1  captured row address and colour words
//   ROW_LEN_ERR                   bit count since previous latch != PANEL_WIDTH
//   FRAME_START                   record is row 0
//   ROW_OE                        HUB_OE level at latch
//   OVERFLOW / OVF_CLR            sticky dropped-row flag and its clear
module hub75_receiver
  import hub75_pkg::*;
#(
  parameter int PANEL_WIDTH    = DEFAULT_PANEL_WIDTH,
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter bit SAMPLE_FALLING = 1'b1
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   HUB_R0,
  input  logic                   HUB_G0,
  input  logic                   HUB_B0,
  input  logic                   HUB_R1,
  input  logic                   HUB_G1,
  input  logic                   HUB_B1,
  input  logic [ADDR_W-1:0]      HUB_ADDR,
  input  logic                   HUB_CLK,
  input  logic                   HUB_LATCH,
  input  logic                   HUB_OE,
  output logic                   ROW_VALID,
  input  logic                   ROW_READY,
  output logic [ADDR_W-1:0]      ROW_ADDR,
  output logic [PANEL_WIDTH-1:0] ROW_RED0,
  output logic [PANEL_WIDTH-1:0] ROW_GRN0,
  output logic [PANEL_WIDTH-1:0] ROW_BLU0,
  output logic [PANEL_WIDTH-1:0] ROW_RED1,
  output logic [PANEL_WIDTH-1:0] ROW_GRN1,
  output logic [PANEL_WIDTH-1:0] ROW_BLU1,
  output logic                   ROW_LEN_ERR,
  output logic                   FRAME_START,
  output logic                   ROW_OE,
  output logic                   OVERFLOW,
  input  logic                   OVF_CLR
);

  localparam int CNT_W = $clog2(PANEL_WIDTH) + 1;
  localparam int BUS_W = NUM_CH + ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PANEL_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(PANEL_WIDTH + 1);

  logic [BUS_W-1:0] bus_raw;
  logic [BUS_W-1:0] bus_lvl;
  logic [BUS_W-1:0] unused_bus_rise;
  logic [BUS_W-1:0] unused_bus_fall;
  logic             hclk_rise;
  logic             hclk_fall;
  logic             unused_hclk_level;
  logic             latch_det;
  logic             unused_latch_level;
  logic             unused_latch_fall;
  logic             shift_en;

  rx_state_e state_q;
  rx_state_e next_state;
  logic      capture;
  logic      drop;

  logic [NUM_CH-1:0][PANEL_WIDTH-1:0] shreg_q;
  logic [NUM_CH-1:0][PANEL_WIDTH-1:0] shreg_next;
  logic [NUM_CH-1:0][PANEL_WIDTH-1:0] rec_q;
  logic [CNT_W-1:0]                   count_q;
  logic [CNT_W-1:0]                   count_next;
  logic [ADDR_W-1:0]                  addr_q;
  logic                               oe_q;
  logic                               len_err_q;
  logic                               frame_q;
  logic                               valid_q;
  logic                               overflow_q;

  // Bit layout: colours at their channel index, then address, then OE.
  assign bus_raw = {HUB_OE, HUB_ADDR, HUB_B1, HUB_G1, HUB_R1, HUB_B0, HUB_G0, HUB_R0};

  hub75_sync_edge #(.WIDTH(BUS_W)) u_sync_bus (
    .clk   (CLK_I),
    .rst   (RST_I),
    .din   (bus_raw),
    .level (bus_lvl),
    .rise  (unused_bus_rise),
    .fall  (unused_bus_fall)
  );

  hub75_sync_edge #(.WIDTH(1)) u_sync_clk (
    .clk   (CLK_I),
    .rst   (RST_I),
    .din   (HUB_CLK),
    .level (unused_hclk_level),
    .rise  (hclk_rise),
    .fall  (hclk_fall)
  );

  hub75_sync_edge #(.WIDTH(1)) u_sync_latch (
    .clk   (CLK_I),
    .rst   (RST_I),
    .din   (HUB_LATCH),
    .level (unused_latch_level),
    .rise  (latch_det),
    .fall  (unused_latch_fall)
  );

  assign shift_en = SAMPLE_FALLING ? hclk_fall : hclk_rise;

  // State register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state and capture decision. The shifted value is computed here so
  // that a HUB_CLK edge coinciding with the latch lands in the record.
  always_comb begin
    next_state = state_q;
    capture    = 1'b0;
    drop       = 1'b0;
    shreg_next = shreg_q;
    count_next = count_q;
    if (shift_en) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        shreg_next[ch] = {bus_lvl[ch], shreg_q[ch][PANEL_WIDTH-1:1]};
      end
      if (count_q != CNT_SAT) begin
        count_next = count_q + 1'b1;
      end
    end
    if (latch_det) begin
      if (state_q == ST_SYNC) begin
        next_state = ST_RUN;
      end else if (!valid_q || ROW_READY) begin
        capture = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Shift registers, bit counter, output record and overflow flag. A new
  // capture takes priority over the valid drop after acceptance, and an
  // overflow set takes priority over a simultaneous clear.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      shreg_q    <= '0;
      count_q    <= '0;
      rec_q      <= '0;
      addr_q     <= '0;
      oe_q       <= 1'b0;
      len_err_q  <= 1'b0;
      frame_q    <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      shreg_q <= shreg_next;
      count_q <= latch_det ? '0 : count_next;
      if (capture) begin
        rec_q     <= shreg_next;
        addr_q    <= bus_lvl[NUM_CH +: ADDR_W];
        oe_q      <= bus_lvl[BUS_W-1];
        len_err_q <= (count_next != CNT_FULL);
        frame_q   <= (bus_lvl[NUM_CH +: ADDR_W] == '0);
        valid_q   <= 1'b1;
      end else if (valid_q && ROW_READY) begin
        valid_q <= 1'b0;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (OVF_CLR) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign ROW_VALID   = valid_q;
  assign ROW_ADDR    = addr_q;
  assign ROW_RED0    = rec_q[CH_R0];
  assign ROW_GRN0    = rec_q[CH_G0];
  assign ROW_BLU0    = rec_q[CH_B0];
  assign ROW_RED1    = rec_q[CH_R1];
  assign ROW_GRN1    = rec_q[CH_G1];
  assign ROW_BLU1    = rec_q[CH_B1];
  assign ROW_LEN_ERR = len_err_q;
  assign FRAME_START = frame_q;
  assign ROW_OE      = oe_q;
  assign OVERFLOW    = overflow_q;

endmodule
